spi_regbank: RTL
================

# spi_regbank

Parametrised SPI (mode 0) register-bank peripheral: next generation of the project's SPI-controlled configuration block. It adds read-back over CIPO, a configurable register count and width, commit-on-deselect semantics, and frame/address error reporting. It sits between the chip-level SPI pins (after pad muxing) and the PWM/output-enable logic. Consumers read a flat register vector and a one-cycle write strobe.

## Interface
- SYNC, 2: synchroniser depth for nCS/SCLK/COPI; must be ≥ 2
- NUM_REGS, 5: number of implemented registers, addresses 0..NUM_REGS-1
- ADDR_W, 7: address field width
- DATA_W, 8: register/data field width; frame length F = 1 + ADDR_W + DATA_W
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- nCS  in  1  SPI chip select, active low, asynchronous to clk
- SCLK  in  1  SPI clock, asynchronous to clk
- COPI  in  1  controller-out data
- CIPO  out  1  peripheral-out data
- cipo_oe  out  1  CIPO output enable (high while a read data phase is active)
- regs_flat  out  NUM_REGS*DATA_W  register i at [i*DATA_W +: DATA_W]
- wr_valid  out  1  one-cycle pulse when a write commits
- wr_addr  out  ADDR_W  address of the last committed write
- frame_err  out  1  one-cycle pulse: frame ended with bit count ≠ F
- addr_err  out  1  one-cycle pulse: complete frame addressed ≥ NUM_REGS

## Operation
- Frame, MSB first: [R/W][ADDR][DATA]; R/W = 1 write, 0 read.
- All three inputs pass through SYNC-flop synchronisers. The nCS chain resets to all-1 (idle), SCLK/COPI chains to 0. Edges are detected on the two oldest stages.
- FSM states: IDLE, HDR, DATA, FULL.
  - IDLE → HDR on synchronised nCS fall; clear bit count and shift register.
  - HDR: each synchronised SCLK rise while nCS low shifts in COPI. After 1+ADDR_W bits → DATA.
  - On the HDR→DATA transition, if R/W = 0: load the out-shifter with the register value (0 if address ≥ NUM_REGS), assert cipo_oe, and drive the data MSB on CIPO.
  - DATA: rises shift COPI. For reads, each synchronised SCLK fall advances CIPO to the next bit. After DATA_W bits → FULL.
  - FULL: any further SCLK rise sets an internal overrun flag.
  - Any state → IDLE on synchronised nCS rise; cipo_oe deasserts and CIPO drives 0 in the same cycle.
- On nCS rise, only one of the following applies:
  - bit count ≠ F or overrun set: frame_err pulse; no register change.
  - Complete frame with address ≥ NUM_REGS: addr_err pulse; no register change. This applies to reads and writes.
  - Complete valid write: register[addr] ← data; wr_addr ← addr; wr_valid pulse.
  - Complete valid read: no side effect.
- A frame with nCS low and zero SCLK rises is silent: no error, no commit.
- COPI data bits in a read frame are ignored.
- Registers change only at a commit. regs_flat is never partially updated.
- Reset, asynchronous and any time including mid-frame:
  - regs_flat = 0, wr_addr = 0, CIPO = 0, cipo_oe = 0, wr_valid = frame_err = addr_err = 0.
  - FSM in IDLE, counters cleared.
  - The in-flight frame is discarded.
- Bit counter width is $clog2(F+1). It saturates at F; overrun is tracked by the flag, so the counter never wraps.

## Timing
- Input-to-detect latency: SYNC clk cycles plus 1 edge-detect cycle.
- SCLK high and low times must each be ≥ SYNC+2 clk periods.
- nCS setup to first SCLK rise and hold after last SCLK fall must each be ≥ SYNC+2 clk periods.
- Commit: regs_flat, wr_addr and the pulse outputs update on the clk edge at which the nCS rise is detected, i.e. SYNC+1 cycles after the pin rises. Pulses are exactly 1 cycle wide.
- CIPO read timing:
  - The first data bit is valid SYNC+1 clk cycles after the SCLK rise that samples the address LSB.
  - Each subsequent bit is valid SYNC+1 clk cycles after each SCLK fall.
  - The controller samples on rising SCLK (mode 0).
- Back-to-back frames: nCS high time ≥ SYNC+2 clk. A new nCS fall is never lost during a commit cycle.

## Test plan
- Write: after reset, frame 0x82A5 (write, addr 2, data 0xA5). Required: wr_valid one pulse, wr_addr = 2, regs_flat[23:16] = 0xA5, all other bits 0.
- Read-back: after the write above, frame 0x0200. Required: CIPO shifts out 1010_0101 during bits 8..15; cipo_oe is high only during that window; regs_flat is unchanged and wr_valid stays 0.
- Short and long frames:
  - 12-bit frame 0x81F: frame_err pulse, register 1 stays 0.
  - 17-bit frame (0x81FF followed by an extra 1): frame_err pulse, register 1 stays 0.
- Address error: frame 0x853C (addr 5, NUM_REGS = 5). Required: addr_err pulse, no register change. Read frame 0x0700: CIPO all zeros plus addr_err.
- Reset mid-frame: deassert rst_n after 9 bits of 0x84FF, release, then raise nCS. Required: all outputs 0, no pulses, register 4 = 0. A following full 0x84FF writes 0xFF.
- Parameter sweep: NUM_REGS = 8, ADDR_W = 3, DATA_W = 16. Write 0xBEEF to addr 7 (frame 0xFBEEF, 20 bits). Required: regs_flat[127:112] = 0xBEEF; read-back returns 0xBEEF MSB first.

Source files
------------

// File: rtl/spi_regbank.sv
// SPI mode-0 register bank: synchronised pin sampling, [R/W][ADDR][DATA] frames,
// read-back over CIPO, and commit-on-deselect with frame/address error pulses.
module spi_regbank #(
    parameter int SYNC     = 2,
    parameter int NUM_REGS = 5,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       nCS,
    input  logic                       SCLK,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_valid,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err,
    output logic                       addr_err
);

    localparam int F        = 1 + ADDR_W + DATA_W;
    localparam int HDR_BITS = 1 + ADDR_W;
    localparam int CW       = $clog2(F + 1);
    localparam logic [CW-1:0] CNT_F        = CW'(F);
    localparam logic [CW-1:0] CNT_HDR      = CW'(HDR_BITS);
    localparam logic [CW-1:0] CNT_HDR_LAST = CW'(HDR_BITS - 1);
    localparam logic [CW-1:0] CNT_F_LAST   = CW'(F - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        FULL = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [SYNC-1:0]   ncs_sync, sclk_sync, copi_sync;
    logic              ncs_prev, sclk_prev;
    logic              ncs_s, sclk_s, copi_s;
    logic              ncs_fall, ncs_rise, sclk_rise, sclk_fall, shift_en;
    logic              load_out, commit;
    logic [CW-1:0]     bit_cnt;
    logic [F-1:0]      shift_q;
    logic              overrun;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   hdr_next;
    logic              frame_rw;
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(NUM_REGS);
    endfunction

    // The extra prev flop after each chain gives the SYNC+1 detect latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_sync  <= '1;
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_prev  <= 1'b1;
            sclk_prev <= 1'b0;
        end else begin
            ncs_sync  <= {ncs_sync[SYNC-2:0], nCS};
            sclk_sync <= {sclk_sync[SYNC-2:0], SCLK};
            copi_sync <= {copi_sync[SYNC-2:0], COPI};
            ncs_prev  <= ncs_sync[SYNC-1];
            sclk_prev <= sclk_sync[SYNC-1];
        end
    end

    assign ncs_s     = ncs_sync[SYNC-1];
    assign sclk_s    = sclk_sync[SYNC-1];
    assign copi_s    = copi_sync[SYNC-1];
    assign ncs_fall  = ncs_prev & ~ncs_s;
    assign ncs_rise  = ~ncs_prev & ncs_s;
    assign sclk_rise = ~sclk_prev & sclk_s;
    assign sclk_fall = sclk_prev & ~sclk_s;
    assign shift_en  = sclk_rise & ~ncs_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ncs_fall) state_d = HDR;
            HDR: begin
                if (ncs_rise) state_d = IDLE;
                else if (shift_en && bit_cnt == CNT_HDR_LAST) state_d = DATA;
            end
            DATA: begin
                if (ncs_rise) state_d = IDLE;
                else if (shift_en && bit_cnt == CNT_F_LAST) state_d = FULL;
            end
            FULL: if (ncs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign load_out   = (state_q == HDR) && (state_d == DATA);
    assign commit     = ncs_rise && (state_q != IDLE);
    assign hdr_next   = {shift_q[ADDR_W-1:0], copi_s};
    assign frame_rw   = shift_q[F-1];
    assign frame_addr = shift_q[F-2 -: ADDR_W];
    assign frame_data = shift_q[DATA_W-1:0];

    // Out-of-range addresses match no register and read back as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hdr_next[ADDR_W-1:0] == ADDR_W'(i)) rd_data = regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_q   <= '0;
            overrun   <= 1'b0;
            out_q     <= '0;
            cipo_oe   <= 1'b0;
            wr_addr   <= '0;
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            addr_err  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            addr_err  <= 1'b0;

            if (state_q == IDLE && ncs_fall) begin
                bit_cnt <= '0;
                shift_q <= '0;
                overrun <= 1'b0;
            end

            if ((state_q == HDR || state_q == DATA) && shift_en && bit_cnt != CNT_F) begin
                shift_q <= {shift_q[F-2:0], copi_s};
                bit_cnt <= bit_cnt + CW'(1);
            end

            if (state_q == FULL && shift_en) overrun <= 1'b1;

            if (load_out) begin
                out_q   <= rd_data;
                cipo_oe <= ~hdr_next[ADDR_W];
            end

            // The fall right after the address LSB must keep the MSB on the line.
            if (state_q == DATA && sclk_fall && cipo_oe && bit_cnt > CNT_HDR)
                out_q <= out_q << 1;

            if (commit) begin
                cipo_oe <= 1'b0;
                if (bit_cnt != '0) begin
                    if (bit_cnt != CNT_F || overrun) begin
                        frame_err <= 1'b1;
                    end else if (!addr_in_range(frame_addr)) begin
                        addr_err <= 1'b1;
                    end else if (frame_rw) begin
                        wr_valid <= 1'b1;
                        wr_addr  <= frame_addr;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (frame_addr == ADDR_W'(i)) regs_q[i] <= frame_data;
                        end
                    end
                end
            end
        end
    end

    assign CIPO = cipo_oe & out_q[DATA_W-1];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule
